// File: rtl/hpdcache_victim_alloc_pkg.sv
// Shared types for the miss-path victim allocation stage.
// Default geometry, set/way vector types, and the allocation FSM encoding.
package hpdcache_victim_alloc_pkg;

  localparam int HPDCACHE_SETS         = 64;
  localparam int HPDCACHE_WAYS         = 4;
  localparam int HPDCACHE_RETRY_CYCLES = 4;
  localparam int HPDCACHE_SET_W        = $clog2(HPDCACHE_SETS);

  typedef logic [HPDCACHE_SET_W-1:0] set_t;
  typedef logic [HPDCACHE_WAYS-1:0]  way_vector_t;

  // Plain vector encoding so the state can be probed by legacy tooling.
  typedef logic [2:0] alloc_state_t;
  localparam alloc_state_t ALLOC_IDLE  = 3'd0;
  localparam alloc_state_t ALLOC_RD    = 3'd1;
  localparam alloc_state_t ALLOC_SEL   = 3'd2;
  localparam alloc_state_t ALLOC_RETRY = 3'd3;
  localparam alloc_state_t ALLOC_WB    = 3'd4;
  localparam alloc_state_t ALLOC_RSP   = 3'd5;

endpackage

// File: rtl/hpdcache_victim_alloc_if.sv
// Bundle of all request, directory, selector, writeback, response and refill signals.
// The slave modport is the allocator's view; master is the surrounding cache's view.
interface hpdcache_victim_alloc_if
  import hpdcache_victim_alloc_pkg::*;
#(
  parameter int SETS = HPDCACHE_SETS,
  parameter int WAYS = HPDCACHE_WAYS
);
  localparam int SET_W = $clog2(SETS);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [SET_W-1:0] req_set_i;
  logic             dir_rd_o;
  logic [SET_W-1:0] dir_rd_set_o;
  logic [WAYS-1:0]  dir_valid_i;
  logic [WAYS-1:0]  dir_wback_i;
  logic [WAYS-1:0]  dir_dirty_i;
  logic [WAYS-1:0]  dir_fetch_i;
  logic [WAYS-1:0]  sel_dir_valid_o;
  logic [WAYS-1:0]  sel_dir_wback_o;
  logic [WAYS-1:0]  sel_dir_dirty_o;
  logic [WAYS-1:0]  sel_dir_fetch_o;
  logic [SET_W-1:0] sel_victim_set_o;
  logic [WAYS-1:0]  sel_victim_way_i;
  logic             fetch_set_o;
  logic [SET_W-1:0] fetch_set_set_o;
  logic [WAYS-1:0]  fetch_set_way_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [SET_W-1:0] wb_set_o;
  logic [WAYS-1:0]  wb_way_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [SET_W-1:0] rsp_set_o;
  logic [WAYS-1:0]  rsp_way_o;
  logic             rsp_evict_o;
  logic             refill_done_i;
  logic [SET_W-1:0] refill_set_i;
  logic [WAYS-1:0]  refill_way_i;
  logic             repl_o;
  logic [SET_W-1:0] repl_set_o;
  logic [WAYS-1:0]  repl_way_o;

  modport slave (
    input  req_valid_i, req_set_i,
    input  dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i,
    input  sel_victim_way_i, wb_ready_i, rsp_ready_i,
    input  refill_done_i, refill_set_i, refill_way_i,
    output req_ready_o, dir_rd_o, dir_rd_set_o,
    output sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o,
    output sel_victim_set_o, fetch_set_o, fetch_set_set_o, fetch_set_way_o,
    output wb_valid_o, wb_set_o, wb_way_o,
    output rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o,
    output repl_o, repl_set_o, repl_way_o
  );

  modport master (
    output req_valid_i, req_set_i,
    output dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i,
    output sel_victim_way_i, wb_ready_i, rsp_ready_i,
    output refill_done_i, refill_set_i, refill_way_i,
    input  req_ready_o, dir_rd_o, dir_rd_set_o,
    input  sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o,
    input  sel_victim_set_o, fetch_set_o, fetch_set_set_o, fetch_set_way_o,
    input  wb_valid_o, wb_set_o, wb_way_o,
    input  rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o,
    input  repl_o, repl_set_o, repl_way_o
  );

endinterface

// File: rtl/hpdcache_victim_alloc.sv
// Miss-path allocation: reads the set's directory, reserves the selected victim way,
// requests a writeback for dirty victims, responds to the miss handler, and forwards refill completions to the PLRU.
module hpdcache_victim_alloc
  import hpdcache_victim_alloc_pkg::*;
#(
  parameter int SETS         = HPDCACHE_SETS,
  parameter int WAYS         = HPDCACHE_WAYS,
  parameter int RETRY_CYCLES = HPDCACHE_RETRY_CYCLES
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  hpdcache_victim_alloc_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int CNT_W = $clog2(RETRY_CYCLES + 1);

  alloc_state_t     r_state;
  logic [SET_W-1:0] r_set;
  logic [WAYS-1:0]  r_way;
  logic             r_evict;
  logic [CNT_W-1:0] r_cnt;
  logic             r_repl;
  logic [SET_W-1:0] r_repl_set;
  logic [WAYS-1:0]  r_repl_way;

  logic w_sel_hit;
  logic w_evict;
  logic w_dirty;

  assign w_sel_hit = |bus.sel_victim_way_i;
  assign w_evict   = |(bus.sel_victim_way_i & bus.dir_valid_i);
  assign w_dirty   = |(bus.sel_victim_way_i & bus.dir_valid_i & bus.dir_dirty_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ALLOC_IDLE;
      r_set   <= '0;
      r_way   <= '0;
      r_evict <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ALLOC_IDLE: begin
          if (bus.req_valid_i) begin
            r_set   <= bus.req_set_i;
            r_state <= ALLOC_RD;
          end
        end
        ALLOC_RD: r_state <= ALLOC_SEL;
        // Every way busy: back off, then re-read since the fetch bits may have cleared.
        ALLOC_SEL: begin
          if (!w_sel_hit) begin
            r_cnt   <= CNT_W'(RETRY_CYCLES);
            r_state <= ALLOC_RETRY;
          end else begin
            r_way   <= bus.sel_victim_way_i;
            r_evict <= w_evict;
            r_state <= w_dirty ? ALLOC_WB : ALLOC_RSP;
          end
        end
        ALLOC_RETRY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ALLOC_RD;
        end
        ALLOC_WB:  if (bus.wb_ready_i)  r_state <= ALLOC_RSP;
        ALLOC_RSP: if (bus.rsp_ready_i) r_state <= ALLOC_IDLE;
        default:   r_state <= ALLOC_IDLE;
      endcase
    end
  end

  // Replacement notification is a free-running one-stage pipe, independent of the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_repl     <= 1'b0;
      r_repl_set <= '0;
      r_repl_way <= '0;
    end else begin
      r_repl     <= bus.refill_done_i;
      r_repl_set <= bus.refill_set_i;
      r_repl_way <= bus.refill_way_i;
    end
  end

  assign bus.req_ready_o      = (r_state == ALLOC_IDLE);
  assign bus.dir_rd_o         = (r_state == ALLOC_RD);
  assign bus.dir_rd_set_o     = r_set;

  assign bus.sel_dir_valid_o  = bus.dir_valid_i;
  assign bus.sel_dir_wback_o  = bus.dir_wback_i;
  assign bus.sel_dir_dirty_o  = bus.dir_dirty_i;
  assign bus.sel_dir_fetch_o  = bus.dir_fetch_i;
  assign bus.sel_victim_set_o = r_set;

  assign bus.fetch_set_o      = (r_state == ALLOC_SEL) && w_sel_hit;
  assign bus.fetch_set_set_o  = r_set;
  assign bus.fetch_set_way_o  = (r_state == ALLOC_SEL) ? bus.sel_victim_way_i : '0;

  assign bus.wb_valid_o       = (r_state == ALLOC_WB);
  assign bus.wb_set_o         = r_set;
  assign bus.wb_way_o         = r_way;

  assign bus.rsp_valid_o      = (r_state == ALLOC_RSP);
  assign bus.rsp_set_o        = r_set;
  assign bus.rsp_way_o        = r_way;
  assign bus.rsp_evict_o      = r_evict;

  assign bus.repl_o           = r_repl;
  assign bus.repl_set_o       = r_repl_set;
  assign bus.repl_way_o       = r_repl_way;

endmodule

// File: tb/tb_hpdcache_victim_alloc.sv
// Directed bench for hpdcache_victim_alloc: cycle-exact checks plus a scoreboard
// of expected responses, writebacks and replacement pulses.
module tb_hpdcache_victim_alloc;
  import hpdcache_victim_alloc_pkg::*;

  typedef struct packed {set_t set; way_vector_t way; logic evict;} rspExp_t;
  typedef struct packed {set_t set; way_vector_t way;} wayExp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks     = 0;
  int passes     = 0;
  int fails      = 0;
  int fetchCount = 0;
  int fetchBefore;

  rspExp_t rspQ[$];
  wayExp_t wbQ[$];
  wayExp_t replQ[$];

  hpdcache_victim_alloc_if busIf ();

  hpdcache_victim_alloc dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (busIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input set_t s, input way_vector_t v, input way_vector_t d,
                               input way_vector_t f, input way_vector_t w);
    busIf.req_valid_i      = 1'b1;
    busIf.req_set_i        = s;
    busIf.dir_valid_i      = v;
    busIf.dir_dirty_i      = d;
    busIf.dir_fetch_i      = f;
    busIf.sel_victim_way_i = w;
  endtask

  // Scoreboard: pop expectations as the DUT completes handshakes and pulses.
  always @(negedge clk) begin : monitor
    rspExp_t re;
    wayExp_t we;
    if (rst_n) begin
      if (busIf.fetch_set_o) fetchCount++;
      if (busIf.rsp_valid_o && busIf.rsp_ready_i) begin
        checkOutput("rsp_expected", 32'(rspQ.size() != 0), 32'(1));
        if (rspQ.size() != 0) begin
          re = rspQ.pop_front();
          checkOutput("rsp_payload", 32'({busIf.rsp_set_o, busIf.rsp_way_o, busIf.rsp_evict_o}), 32'(re));
        end
      end
      if (busIf.wb_valid_o && busIf.wb_ready_i) begin
        checkOutput("wb_expected", 32'(wbQ.size() != 0), 32'(1));
        if (wbQ.size() != 0) begin
          we = wbQ.pop_front();
          checkOutput("wb_payload", 32'({busIf.wb_set_o, busIf.wb_way_o}), 32'(we));
        end
      end
      if (busIf.repl_o) begin
        checkOutput("repl_expected", 32'(replQ.size() != 0), 32'(1));
        if (replQ.size() != 0) begin
          we = replQ.pop_front();
          checkOutput("repl_payload", 32'({busIf.repl_set_o, busIf.repl_way_o}), 32'(we));
        end
      end
    end
  end

  initial begin
    busIf.req_valid_i      = 1'b0;
    busIf.req_set_i        = '0;
    busIf.dir_valid_i      = '0;
    busIf.dir_wback_i      = '0;
    busIf.dir_dirty_i      = '0;
    busIf.dir_fetch_i      = '0;
    busIf.sel_victim_way_i = '0;
    busIf.wb_ready_i       = 1'b0;
    busIf.rsp_ready_i      = 1'b0;
    busIf.refill_done_i    = 1'b0;
    busIf.refill_set_i     = '0;
    busIf.refill_way_i     = '0;

    repeat (2) sampleEdge();
    checkOutput("reset_req_ready", 32'(busIf.req_ready_o), 32'(1));
    checkOutput("reset_dir_rd", 32'(busIf.dir_rd_o), 32'(0));
    checkOutput("reset_fetch_set", 32'(busIf.fetch_set_o), 32'(0));
    checkOutput("reset_wb_valid", 32'(busIf.wb_valid_o), 32'(0));
    checkOutput("reset_rsp_valid", 32'(busIf.rsp_valid_o), 32'(0));
    checkOutput("reset_repl", 32'(busIf.repl_o), 32'(0));
    checkOutput("reset_rsp_set_way", 32'({busIf.rsp_set_o, busIf.rsp_way_o}), 32'(0));
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Clean, invalid victim: rd in cycle 1, fetch in cycle 2, rsp from cycle 3.
    busIf.rsp_ready_i = 1'b1;
    busIf.dir_wback_i = 4'b1010;
    applyStimulus(set_t'(5), 4'b0011, 4'b0000, 4'b0000, 4'b0100);
    rspQ.push_back({set_t'(5), way_vector_t'(4'b0100), 1'b0});
    sampleEdge();
    checkOutput("t1_req_ready", 32'(busIf.req_ready_o), 32'(1));
    nextCycle();
    busIf.req_valid_i = 1'b0;
    sampleEdge();
    checkOutput("t1_dir_rd", 32'(busIf.dir_rd_o), 32'(1));
    checkOutput("t1_dir_rd_set", 32'(busIf.dir_rd_set_o), 32'(5));
    checkOutput("t1_sel_wback_pass", 32'(busIf.sel_dir_wback_o), 32'(4'b1010));
    checkOutput("t1_sel_valid_pass", 32'(busIf.sel_dir_valid_o), 32'(4'b0011));
    nextCycle();
    sampleEdge();
    checkOutput("t1_fetch_set", 32'(busIf.fetch_set_o), 32'(1));
    checkOutput("t1_fetch_way", 32'(busIf.fetch_set_way_o), 32'(4'b0100));
    checkOutput("t1_fetch_set_set", 32'(busIf.fetch_set_set_o), 32'(5));
    checkOutput("t1_sel_victim_set", 32'(busIf.sel_victim_set_o), 32'(5));
    nextCycle();
    sampleEdge();
    checkOutput("t1_rsp_valid", 32'(busIf.rsp_valid_o), 32'(1));
    checkOutput("t1_no_wb", 32'(busIf.wb_valid_o), 32'(0));
    nextCycle();
    sampleEdge();
    checkOutput("t1_idle_again", 32'(busIf.req_ready_o), 32'(1));

    // Dirty victim: writeback held stable under back-pressure, then rsp with evict.
    nextCycle();
    busIf.dir_wback_i = '0;
    applyStimulus(set_t'(9), 4'b1111, 4'b1111, 4'b0000, 4'b0010);
    wbQ.push_back({set_t'(9), way_vector_t'(4'b0010)});
    rspQ.push_back({set_t'(9), way_vector_t'(4'b0010), 1'b1});
    nextCycle();
    busIf.req_valid_i = 1'b0;
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      sampleEdge();
      checkOutput("t2_wb_valid_hold", 32'(busIf.wb_valid_o), 32'(1));
      checkOutput("t2_wb_payload_hold", 32'({busIf.wb_set_o, busIf.wb_way_o}), 32'({6'd9, 4'b0010}));
      checkOutput("t2_rsp_not_yet", 32'(busIf.rsp_valid_o), 32'(0));
    end
    nextCycle();
    busIf.wb_ready_i = 1'b1;
    sampleEdge();
    checkOutput("t2_wb_valid_hs", 32'(busIf.wb_valid_o), 32'(1));
    nextCycle();
    busIf.wb_ready_i = 1'b0;
    sampleEdge();
    checkOutput("t2_rsp_valid", 32'(busIf.rsp_valid_o), 32'(1));
    checkOutput("t2_rsp_evict", 32'(busIf.rsp_evict_o), 32'(1));
    nextCycle();
    sampleEdge();
    checkOutput("t2_idle_again", 32'(busIf.req_ready_o), 32'(1));

    // All ways fetching: exactly RETRY_CYCLES idle cycles, then a fresh directory read.
    fetchBefore = fetchCount;
    nextCycle();
    applyStimulus(set_t'(2), 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rspQ.push_back({set_t'(2), way_vector_t'(4'b0001), 1'b1});
    nextCycle();
    busIf.req_valid_i = 1'b0;
    sampleEdge();
    checkOutput("t3_dir_rd_first", 32'(busIf.dir_rd_o), 32'(1));
    nextCycle();
    sampleEdge();
    checkOutput("t3_no_fetch", 32'(busIf.fetch_set_o), 32'(0));
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      sampleEdge();
      checkOutput("t3_retry_no_rd", 32'(busIf.dir_rd_o), 32'(0));
      checkOutput("t3_retry_not_ready", 32'(busIf.req_ready_o), 32'(0));
    end
    nextCycle();
    busIf.dir_fetch_i      = 4'b0000;
    busIf.sel_victim_way_i = 4'b0001;
    sampleEdge();
    checkOutput("t3_dir_rd_again", 32'(busIf.dir_rd_o), 32'(1));
    checkOutput("t3_dir_rd_set", 32'(busIf.dir_rd_set_o), 32'(2));
    nextCycle();
    sampleEdge();
    checkOutput("t3_fetch_way", 32'({busIf.fetch_set_o, busIf.fetch_set_way_o}), 32'({1'b1, 4'b0001}));
    nextCycle();
    sampleEdge();
    checkOutput("t3_rsp_valid", 32'(busIf.rsp_valid_o), 32'(1));
    nextCycle();
    sampleEdge();
    checkOutput("t3_one_fetch_pulse", 32'(fetchCount - fetchBefore), 32'(1));

    // Response back-pressure with a second request already waiting.
    nextCycle();
    busIf.rsp_ready_i = 1'b0;
    applyStimulus(set_t'(7), 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    rspQ.push_back({set_t'(7), way_vector_t'(4'b1000), 1'b0});
    rspQ.push_back({set_t'(12), way_vector_t'(4'b1000), 1'b0});
    sampleEdge();
    checkOutput("t4_first_accept", 32'(busIf.req_ready_o), 32'(1));
    nextCycle();
    busIf.req_set_i = set_t'(12);
    sampleEdge();
    checkOutput("t4_busy_ready", 32'(busIf.req_ready_o), 32'(0));
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      sampleEdge();
      checkOutput("t4_busy_ready", 32'(busIf.req_ready_o), 32'(0));
    end
    nextCycle();
    busIf.rsp_ready_i = 1'b1;
    sampleEdge();
    checkOutput("t4_rsp_held", 32'(busIf.rsp_valid_o), 32'(1));
    checkOutput("t4_hs_not_ready", 32'(busIf.req_ready_o), 32'(0));
    nextCycle();
    sampleEdge();
    checkOutput("t4_second_accept", 32'(busIf.req_ready_o), 32'(1));
    nextCycle();
    busIf.req_valid_i = 1'b0;
    sampleEdge();
    checkOutput("t4_second_rd_set", 32'({busIf.dir_rd_o, busIf.dir_rd_set_o}), 32'({1'b1, 6'd12}));
    nextCycle();
    nextCycle();
    sampleEdge();
    checkOutput("t4_second_rsp", 32'(busIf.rsp_valid_o), 32'(1));
    nextCycle();

    // Back-to-back refill completions overlapping SEL.
    applyStimulus(set_t'(20), 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    rspQ.push_back({set_t'(20), way_vector_t'(4'b0001), 1'b0});
    nextCycle();
    busIf.req_valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      busIf.refill_done_i = 1'b1;
      busIf.refill_set_i  = set_t'(i);
      busIf.refill_way_i  = way_vector_t'(1 << (i - 1));
      replQ.push_back({set_t'(i), way_vector_t'(1 << (i - 1))});
    end
    nextCycle();
    busIf.refill_done_i = 1'b0;
    sampleEdge();
    checkOutput("t5_last_repl", 32'({busIf.repl_o, busIf.repl_set_o}), 32'({1'b1, 6'd3}));
    nextCycle();
    sampleEdge();
    checkOutput("t5_repl_done", 32'(busIf.repl_o), 32'(0));

    // Reset while a writeback is pending abandons the allocation.
    nextCycle();
    busIf.wb_ready_i = 1'b0;
    applyStimulus(set_t'(30), 4'b1111, 4'b1111, 4'b0000, 4'b1000);
    nextCycle();
    busIf.req_valid_i = 1'b0;
    nextCycle();
    nextCycle();
    sampleEdge();
    checkOutput("t6_in_wb", 32'(busIf.wb_valid_o), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_wb_valid", 32'(busIf.wb_valid_o), 32'(0));
    checkOutput("t6_reset_req_ready", 32'(busIf.req_ready_o), 32'(1));
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      sampleEdge();
      checkOutput("t6_no_rsp", 32'(busIf.rsp_valid_o), 32'(0));
      checkOutput("t6_no_wb", 32'(busIf.wb_valid_o), 32'(0));
      checkOutput("t6_idle_ready", 32'(busIf.req_ready_o), 32'(1));
    end

    checkOutput("end_rsp_queue", 32'(rspQ.size()), 32'(0));
    checkOutput("end_wb_queue", 32'(wbQ.size()), 32'(0));
    checkOutput("end_repl_queue", 32'(replQ.size()), 32'(0));
    checkOutput("end_fetch_pulses", 32'(fetchCount), 32'(7));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_victim_alloc.md
Name: hpdcache_victim_alloc

Overview:
Miss-path allocation stage in front of the PLRU victim selector. It takes a refill-allocation request for a set and reads that set's directory state. It feeds the state to the victim selector, reserves the chosen way by setting its fetch bit, and issues a writeback request when the victim is dirty. It then hands the set/way to the miss handler; when the refill completes, it sends the replacement pulse to the PLRU.

Parameters:
SETS, 64, number of cache sets (power of two, >=2)
WAYS, 4, number of ways (>=2)
RETRY_CYCLES, 4, wait cycles before re-reading the directory when no way is selectable (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  allocation request valid
req_ready_o  out  1  allocation request ready
req_set_i  in  log2(SETS)  set to allocate in
dir_rd_o  out  1  directory read strobe
dir_rd_set_o  out  log2(SETS)  directory read set
dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i  in  WAYS each  directory state; valid the cycle after dir_rd_o
sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o  out  WAYS each  directory state forwarded to the victim selector
sel_victim_set_o  out  log2(SETS)  set presented to the victim selector
sel_victim_way_i  in  WAYS  one-hot victim from the selector (combinational), or 0 if none
fetch_set_o  out  1  pulse: set the fetch bit of fetch_set_set_o / fetch_set_way_o
fetch_set_set_o  out  log2(SETS)  set for the fetch-bit update
fetch_set_way_o  out  WAYS  one-hot way for the fetch-bit update
wb_valid_o  out  1  dirty-victim writeback request valid
wb_ready_i  in  1  writeback request ready
wb_set_o  out  log2(SETS)  writeback set
wb_way_o  out  WAYS  writeback way
rsp_valid_o  out  1  allocation response valid
rsp_ready_i  in  1  allocation response ready
rsp_set_o  out  log2(SETS)  allocated set
rsp_way_o  out  WAYS  allocated one-hot way
rsp_evict_o  out  1  victim held a valid line
refill_done_i  in  1  refill of refill_set_i / refill_way_i complete
refill_set_i  in  log2(SETS)  completed refill set
refill_way_i  in  WAYS  completed refill way
repl_o  out  1  PLRU replacement pulse
repl_set_o  out  log2(SETS)  PLRU replacement set
repl_way_o  out  WAYS  PLRU replacement way

Behaviour:
- Reset values: FSM=IDLE; req_ready_o=1; all valid/strobe/pulse outputs 0; set/way registers 0; retry counter 0.
- Reset asserted mid-operation abandons the request: no fetch_set_o, wb or rsp is emitted, and the FSM returns to IDLE.
- FSM states: IDLE, RD, SEL, RETRY, WB, RSP.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch req_set_i and go to RD.
- req_ready_o=0 in every state other than IDLE.
- RD: dir_rd_o=1 for exactly 1 cycle, with dir_rd_set_o = latched set; go to SEL.
- SEL:
  - sel_dir_*_o = dir_*_i (pure pass-through in every state); sel_victim_set_o = latched set (in every state).
  - If sel_victim_way_i == 0: go to RETRY, load counter = RETRY_CYCLES.
  - Else:
    - latch way;
    - pulse fetch_set_o for 1 cycle, with the latched set/way;
    - evict = |(way & dir_valid_i);
    - dirty = |(way & dir_valid_i & dir_dirty_i);
    - go to WB if dirty, else RSP.
- RETRY: decrement the counter each cycle; when it reaches 1, go to RD. This gives exactly RETRY_CYCLES cycles in RETRY.
- WB: wb_valid_o=1 with the latched set/way, held stable until wb_ready_i; on handshake go to RSP.
- RSP: rsp_valid_o=1, held stable until rsp_ready_i; on handshake go to IDLE.
- rsp_evict_o is 1 for dirty victims as well as for clean valid victims.
- Latency, clean victim with no back-pressure: request accepted in cycle 0, dir_rd_o in cycle 1, fetch_set_o in cycle 2, rsp_valid_o from cycle 3. Back-to-back requests are accepted at most every 4 cycles.
- Replacement path, independent of the FSM:
  - refill_done_i is registered; repl_o is asserted the cycle after it, with the registered set/way, for 1 cycle.
  - One refill_done_i per cycle is supported with no loss.
  - It may coincide with any FSM state, including fetch_set_o in the same cycle.
- No combinational path from any *_ready_i to any *_valid_o. sel_victim_way_i is used only in SEL.

Decomposition:
- Shared hpdcache package: set_t and way_vector_t typedefs, parameterised by SETS/WAYS, plus an FSM state enum for this block.
- Sub-module: none needed. The retry counter is inline; the one-hot victim encoding stays in the selector.

Test Plan:
- SETS=64, WAYS=4. Request set 5; dir_valid=4'b0011; selector returns 4'b0100 -> dir_rd in cycle 1 (set 5); fetch_set_o in cycle 2 (way 4'b0100); rsp in cycle 3 with set 5, way 4'b0100, evict=0; no wb.
- Request set 9; valid=dirty=4'b1111; selector returns 4'b0010 -> wb_valid_o with set 9, way 4'b0010. Hold wb_ready_i=0 for 3 cycles: wb outputs stay stable. Then rsp with evict=1.
- Request set 2; fetch=4'b1111, selector returns 0 -> RETRY for exactly 4 cycles, then dir_rd re-issued. Clear fetch bits: allocation completes, exactly one fetch_set_o pulse.
- rsp_ready_i low for 5 cycles while req_valid_i is held -> req_ready_o=0 throughout; the new request is accepted the cycle after the rsp handshake.
- refill_done_i on 3 consecutive cycles (sets 1, 2, 3) during SEL -> repl_o on the next 3 cycles with sets 1, 2, 3 in order.
- rst_ni asserted during WB -> wb_valid_o=0 and req_ready_o=1 immediately; no rsp follows.
